hdlc_line_monitor: RTL and testbench
====================================

# hdlc_line_monitor

Synthesizable, parametrised run-time monitor for HDLC serial lines, carrying the bench-side protocol checks into RTL: flag, abort and idle detection, zero-stuffing awareness and frame-length validation. It adds multi-channel operation, per-channel event pulses and saturating statistics counters. It sits beside the HDLC Rx/Tx datapaths and taps up to CHANNELS serial lines (Rx or Tx) without affecting them.

## Interface
- CHANNELS, 2: number of monitored lines, ≥1.
- CNT_W, 8: width of each statistics counter.
- MIN_FRAME_BITS, 32: minimum legal frame content length in bits, destuffed.
- MAX_FRAME_BITS, 1024: maximum legal frame content length in bits, destuffed.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  reset, asynchronous, active-low.
- Line  in  CHANNELS  serial bit per channel.
- BitEn  in  CHANNELS  per-channel bit strobe; Line[i] is sampled only when BitEn[i]=1.
- CntClr  in  1  synchronous clear of all counters.
- CntSel  in  $clog2(CHANNELS) (min 1)  channel selected for counter readout.
- InSync  out  CHANNELS  1 = channel is not in HUNT.
- Flag_Evt, FrameOk_Evt, FrameErr_Evt, Abort_Evt  out  CHANNELS each  one-cycle event pulses.
- Rd_FrameOk, Rd_FrameErr, Rd_Abort  out  CNT_W each  counters of channel CntSel; 0 if CntSel ≥ CHANNELS.

## Operation
Per channel, on each cycle with BitEn=1, bit b:
- Ones: count of consecutive ones, saturating at 7.
  - b=1: increment; b=0: clear.
  - Reset value is 7 (line treated as idle).
- Stuffed zero: b=0 with Ones==5. The bit is discarded and not counted.
- Flag: b=0 with Ones==6.
- Abort pattern: b=1 with Ones==6 (the seventh one). Further ones produce nothing.
- BitCnt: destuffed bits since the last flag, including the current bit.
  - Cleared on flag.
  - Saturates at MAX_FRAME_BITS+9.
- States:
  - HUNT, reset state. On flag: go to OPEN, pulse Flag_Evt, clear BitCnt.
  - OPEN: flag seen, no content yet.
    - Flag: pulse Flag_Evt, stay in OPEN (shared or back-to-back flags).
    - Abort pattern: idle after the closing flag; go to HUNT with no event.
    - BitCnt reaching 8: go to FRAME.
  - FRAME:
    - Flag: compute content c = BitCnt−8. If c%8==0 and MIN_FRAME_BITS ≤ c ≤ MAX_FRAME_BITS, pulse FrameOk_Evt; otherwise pulse FrameErr_Evt. Also pulse Flag_Evt, then go to OPEN.
    - Abort pattern: pulse Abort_Evt, go to HUNT.
    - BitCnt exceeding MAX_FRAME_BITS+8: pulse FrameErr_Evt, go to HUNT.
- Counters, per channel: FrameOk, FrameErr and Abort.
  - Each increments on its event and saturates at 2^CNT_W−1.
  - CntClr overrides a simultaneous increment; the counter result is 0.
- BitEn=0 freezes all channel state; no events are generated.
- Channels are fully independent.

## Timing
- Reset values:
  - All event outputs, InSync and counters: 0.
  - State HUNT, Ones 7, BitCnt 0.
- Event latency: a pulse is high for exactly one cycle, in the cycle after the Clk edge that sampled the completing bit.
- The counter increment is visible in the same cycle as the event pulse.
- InSync follows the registered state: it rises together with the first Flag_Evt and falls in the cycle after the bit that forces HUNT.
- Rd_* outputs are a combinational mux of the registered counters. A CntSel change is reflected in the same cycle.
- Flag and FrameOk/FrameErr pulse together on a closing flag.
- Reset asserted mid-frame: outputs clear immediately. A new opening flag is required before any frame event.

## Structure
- Package hdlc_mon_pkg holds:
  - State enum (HUNT, OPEN, FRAME).
  - FLAG_OVERHEAD = 8.
  - ONES_FLAG = 6 and ONES_STUFF = 5.
  - Event struct {flag, ok, err, abort}.
- Sub-module hdlc_mon_chan implements one channel: the Ones counter, BitCnt, the state machine and the event register.
- The top level contains:
  - A generate loop of CHANNELS hdlc_mon_chan instances.
  - The saturating counters.
  - The readout mux.

## Test plan
- Channel 0, 10 ones then bits 0,1,1,1,1,1,1,0: Flag_Evt[0] pulses one cycle after the final 0 and InSync[0]=1. No frame event; channel 1 is unaffected.
- Flag, payload 0xA5 0x3C (16 bits, no stuffing), flag, with MIN_FRAME_BITS=16: FrameOk_Evt pulses and Rd_FrameOk=1 with CntSel=0.
- Flag, payload 0xFF 0xFF 0x00 0x00 transmitted with stuffed zeros (35 line bits), flag: FrameOk_Evt pulses and FrameErr_Evt stays 0.
- Flag, 12 payload bits, flag: FrameErr_Evt pulses. A subsequent 20-bit payload followed by 0 and seven ones: Abort_Evt pulses and InSync drops. Flag followed by 20 idle ones: no Abort_Evt.
- CNT_W=2 with five good frames: Rd_FrameOk saturates at 3. CntClr in the same cycle as a FrameOk pulse: the counter reads 0.
- Rst asserted mid-frame: all outputs are 0. The next payload without an opening flag produces no events, and InSync stays 0 until a flag arrives.

Source files
------------

// File: rtl/hdlc_mon_pkg.sv
// Shared types and constants for the HDLC line monitor.
package hdlc_mon_pkg;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        OPEN  = 2'd1,
        FRAME = 2'd2
    } hdlc_state_e;

    // Bits of the closing flag that land in BitCnt before the flag is recognised.
    localparam int FLAG_OVERHEAD = 8;
    localparam int ONES_FLAG     = 6;
    localparam int ONES_STUFF    = 5;

    typedef struct packed {
        logic flag;
        logic ok;
        logic err;
        logic abort;
    } hdlc_evt_t;

endpackage

// File: rtl/hdlc_mon_chan.sv
// One monitored HDLC line: ones run, destuffed bit count, framing FSM and
// registered event pulses.
module hdlc_mon_chan
    import hdlc_mon_pkg::*;
#(
    parameter int MIN_FRAME_BITS = 32,
    parameter int MAX_FRAME_BITS = 1024
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    input  logic      i_bit,
    input  logic      i_bit_en,
    output hdlc_evt_t o_evt,
    output logic      o_inc_ok,
    output logic      o_inc_err,
    output logic      o_inc_abort,
    output logic      o_in_sync
);

    localparam int CNT_MAX = MAX_FRAME_BITS + FLAG_OVERHEAD + 1;
    localparam int BW      = $clog2(CNT_MAX + 1);
    localparam logic [BW-1:0] C_SAT  = BW'(CNT_MAX);
    localparam logic [BW-1:0] C_OPEN = BW'(FLAG_OVERHEAD);
    localparam logic [BW-1:0] C_LO   = BW'(MIN_FRAME_BITS + FLAG_OVERHEAD);
    localparam logic [BW-1:0] C_HI   = BW'(MAX_FRAME_BITS + FLAG_OVERHEAD);

    hdlc_state_e   r_state, w_state_nxt;
    logic [2:0]    r_ones, w_ones_nxt;
    logic [BW-1:0] r_bitcnt, w_bitcnt_nxt, w_cnt_inc;
    hdlc_evt_t     r_evt, w_evt_nxt;
    logic          w_stuff, w_flag, w_abort;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= HUNT;
            r_ones   <= 3'd7;
            r_bitcnt <= '0;
            r_evt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_ones   <= w_ones_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_evt    <= w_evt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_ones_nxt   = r_ones;
        w_bitcnt_nxt = r_bitcnt;
        w_evt_nxt    = '0;
        w_stuff      = i_bit_en && !i_bit && (r_ones == 3'(ONES_STUFF));
        w_flag       = i_bit_en && !i_bit && (r_ones == 3'(ONES_FLAG));
        w_abort      = i_bit_en &&  i_bit && (r_ones == 3'(ONES_FLAG));
        w_cnt_inc    = (r_bitcnt == C_SAT) ? r_bitcnt : r_bitcnt + BW'(1);

        if (i_bit_en) begin
            if (i_bit)
                w_ones_nxt = (r_ones == 3'd7) ? r_ones : r_ones + 3'd1;
            else
                w_ones_nxt = 3'd0;

            if (!w_stuff)
                w_bitcnt_nxt = w_cnt_inc;

            if (w_flag) begin
                // w_cnt_inc includes the whole closing flag, so content = inc - 8.
                w_bitcnt_nxt   = '0;
                w_state_nxt    = OPEN;
                w_evt_nxt.flag = 1'b1;
                if (r_state == FRAME) begin
                    if ((w_cnt_inc[2:0] == 3'd0) && (w_cnt_inc >= C_LO) && (w_cnt_inc <= C_HI))
                        w_evt_nxt.ok = 1'b1;
                    else
                        w_evt_nxt.err = 1'b1;
                end
            end else if (w_abort) begin
                // Seven ones after a flag with no content is plain idle.
                w_state_nxt     = HUNT;
                w_evt_nxt.abort = (r_state == FRAME);
            end else if (!w_stuff) begin
                case (r_state)
                    OPEN: begin
                        if (w_cnt_inc == C_OPEN)
                            w_state_nxt = FRAME;
                    end
                    FRAME: begin
                        if (w_cnt_inc == C_SAT) begin
                            w_state_nxt   = HUNT;
                            w_evt_nxt.err = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_evt       = r_evt;
    assign o_inc_ok    = w_evt_nxt.ok;
    assign o_inc_err   = w_evt_nxt.err;
    assign o_inc_abort = w_evt_nxt.abort;
    assign o_in_sync   = (r_state != HUNT);

endmodule

// File: rtl/hdlc_line_monitor.sv
// hdlc_line_monitor: passive multi-channel HDLC line checker with event
// pulses and saturating per-channel frame/abort statistics.
module hdlc_line_monitor
    import hdlc_mon_pkg::*;
#(
    parameter int  CHANNELS       = 2,
    parameter int  CNT_W          = 8,
    parameter int  MIN_FRAME_BITS = 32,
    parameter int  MAX_FRAME_BITS = 1024,
    localparam int SEL_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                i_Clk,
    input  logic                i_Rst,
    input  logic [CHANNELS-1:0] i_Line,
    input  logic [CHANNELS-1:0] i_BitEn,
    input  logic                i_CntClr,
    input  logic [SEL_W-1:0]    i_CntSel,
    output logic [CHANNELS-1:0] o_InSync,
    output logic [CHANNELS-1:0] o_Flag_Evt,
    output logic [CHANNELS-1:0] o_FrameOk_Evt,
    output logic [CHANNELS-1:0] o_FrameErr_Evt,
    output logic [CHANNELS-1:0] o_Abort_Evt,
    output logic [CNT_W-1:0]    o_Rd_FrameOk,
    output logic [CNT_W-1:0]    o_Rd_FrameErr,
    output logic [CNT_W-1:0]    o_Rd_Abort
);

    logic [CHANNELS-1:0][CNT_W-1:0] w_cnt_ok, w_cnt_err, w_cnt_ab;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        hdlc_evt_t        w_evt;
        logic             w_inc_ok, w_inc_err, w_inc_ab;
        logic [CNT_W-1:0] r_ok, r_err, r_ab;

        hdlc_mon_chan #(
            .MIN_FRAME_BITS (MIN_FRAME_BITS),
            .MAX_FRAME_BITS (MAX_FRAME_BITS)
        ) u_chan (
            .i_clk       (i_Clk),
            .i_rst_n     (i_Rst),
            .i_bit       (i_Line[g]),
            .i_bit_en    (i_BitEn[g]),
            .o_evt       (w_evt),
            .o_inc_ok    (w_inc_ok),
            .o_inc_err   (w_inc_err),
            .o_inc_abort (w_inc_ab),
            .o_in_sync   (o_InSync[g])
        );

        // Counters take the pre-register event so they update alongside the pulse.
        always_ff @(posedge i_Clk or negedge i_Rst) begin
            if (!i_Rst) begin
                r_ok  <= '0;
                r_err <= '0;
                r_ab  <= '0;
            end else if (i_CntClr) begin
                r_ok  <= '0;
                r_err <= '0;
                r_ab  <= '0;
            end else begin
                if (w_inc_ok  && (r_ok  != '1)) r_ok  <= r_ok  + CNT_W'(1);
                if (w_inc_err && (r_err != '1)) r_err <= r_err + CNT_W'(1);
                if (w_inc_ab  && (r_ab  != '1)) r_ab  <= r_ab  + CNT_W'(1);
            end
        end

        assign o_Flag_Evt[g]     = w_evt.flag;
        assign o_FrameOk_Evt[g]  = w_evt.ok;
        assign o_FrameErr_Evt[g] = w_evt.err;
        assign o_Abort_Evt[g]    = w_evt.abort;
        assign w_cnt_ok[g]       = r_ok;
        assign w_cnt_err[g]      = r_err;
        assign w_cnt_ab[g]       = r_ab;
    end

    // Out-of-range selects fall through to zero.
    always_comb begin
        o_Rd_FrameOk  = '0;
        o_Rd_FrameErr = '0;
        o_Rd_Abort    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (i_CntSel == SEL_W'(i)) begin
                o_Rd_FrameOk  = w_cnt_ok[i];
                o_Rd_FrameErr = w_cnt_err[i];
                o_Rd_Abort    = w_cnt_ab[i];
            end
        end
    end

endmodule

// File: tb/tb_hdlc_line_monitor.sv
// Directed bench for hdlc_line_monitor: 3 channels, 2-bit counters, 16..64 bit frames.
module tb_hdlc_line_monitor;

    logic       clk, rst_n, clr;
    logic [2:0] line, en;
    logic [1:0] sel;
    logic [2:0] in_sync, flag_evt, ok_evt, err_evt, ab_evt;
    logic [1:0] rd_ok, rd_err, rd_ab;

    int         n_cmp, n_bad, tx_ones, exp_ok;
    logic [2:0] acc_flag, acc_ok, acc_err, acc_ab;

    hdlc_line_monitor #(
        .CHANNELS       (3),
        .CNT_W          (2),
        .MIN_FRAME_BITS (16),
        .MAX_FRAME_BITS (64)
    ) dut (
        .i_Clk          (clk),
        .i_Rst          (rst_n),
        .i_Line         (line),
        .i_BitEn        (en),
        .i_CntClr       (clr),
        .i_CntSel       (sel),
        .o_InSync       (in_sync),
        .o_Flag_Evt     (flag_evt),
        .o_FrameOk_Evt  (ok_evt),
        .o_FrameErr_Evt (err_evt),
        .o_Abort_Evt    (ab_evt),
        .o_Rd_FrameOk   (rd_ok),
        .o_Rd_FrameErr  (rd_err),
        .o_Rd_Abort     (rd_ab)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr_acc();
        acc_flag = '0; acc_ok = '0; acc_err = '0; acc_ab = '0;
    endtask

    // One line bit on one channel; outputs sampled 1 time unit after the edge.
    task automatic send_bit(input int ch, input logic b);
        @(negedge clk);
        line[ch] = b;
        en[ch]   = 1'b1;
        @(posedge clk);
        #1;
        en[ch]   = 1'b0;
        acc_flag |= flag_evt;
        acc_ok   |= ok_evt;
        acc_err  |= err_evt;
        acc_ab   |= ab_evt;
        tx_ones  = b ? tx_ones + 1 : 0;
    endtask

    // Payload bits, LSB first, with transmitter-side zero insertion.
    task automatic send_bits(input int ch, input logic [31:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            send_bit(ch, v[i]);
            if (v[i] && tx_ones == 5) send_bit(ch, 1'b0);
        end
    endtask

    task automatic send_flag(input int ch, input logic clr_last);
        logic [7:0] f;
        f = 8'h7E;
        for (int i = 0; i < 7; i++) send_bit(ch, f[i]);
        clr = clr_last;
        send_bit(ch, f[7]);
        clr = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; tx_ones = 0; exp_ok = 0;
        rst_n = 1'b0; clr = 1'b0; line = '0; en = '0; sel = 2'd0;
        clr_acc();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_insync", in_sync, 3'b000);
        chk("rst_flag",   flag_evt, 3'b000);
        chk("rst_frame",  {ok_evt, err_evt, ab_evt}, 9'd0);
        chk("rst_rd",     {rd_ok, rd_err, rd_ab}, 6'd0);

        // Idle ones then a flag on channel 0
        for (int i = 0; i < 10; i++) send_bit(0, 1'b1);
        send_flag(0, 1'b0);
        chk("t1_flag",     flag_evt, 3'b001);
        chk("t1_insync",   in_sync, 3'b001);
        chk("t1_noframe",  {ok_evt, err_evt}, 6'd0);
        chk("t1_flagonce", acc_flag, 3'b001);
        @(posedge clk); #1;
        chk("t1_pulse1cy", flag_evt, 3'b000);

        // 16-bit payload A5 3C
        clr_acc();
        send_bits(0, 32'h3CA5, 16);
        send_flag(0, 1'b0);
        chk("t2_ok",   ok_evt, 3'b001);
        chk("t2_flag", flag_evt, 3'b001);
        chk("t2_err",  err_evt, 3'b000);
        chk("t2_rdok", rd_ok, 2'd1);

        // FF FF 00 00 with three stuffed zeros
        clr_acc();
        send_bits(0, 32'h0000FFFF, 32);
        send_flag(0, 1'b0);
        chk("t3_ok",    ok_evt, 3'b001);
        chk("t3_noerr", acc_err, 3'b000);
        chk("t3_rdok",  rd_ok, 2'd2);
        exp_ok = 2;

        // 12-bit payload is a length error
        clr_acc();
        send_bits(0, 32'h5A5, 12);
        send_flag(0, 1'b0);
        chk("t4_err",   err_evt, 3'b001);
        chk("t4_ok",    acc_ok, 3'b000);
        chk("t4_rderr", rd_err, 2'd1);

        // 20 bits, then 0 and seven ones: abort
        clr_acc();
        send_bits(0, 32'hA5A5A, 20);
        send_bit(0, 1'b0);
        for (int i = 0; i < 7; i++) send_bit(0, 1'b1);
        chk("t4_abort",      ab_evt, 3'b001);
        chk("t4_abort_sync", in_sync, 3'b000);
        chk("t4_rdab",       rd_ab, 2'd1);

        // Flag followed by idle is not an abort
        clr_acc();
        send_flag(0, 1'b0);
        chk("t4_resync", in_sync, 3'b001);
        for (int i = 0; i < 20; i++) send_bit(0, 1'b1);
        chk("t4_idle_noab",  acc_ab, 3'b000);
        chk("t4_idle_noerr", acc_err, 3'b000);
        chk("t4_idle_sync",  in_sync, 3'b000);
        chk("t4_idle_rdab",  rd_ab, 2'd1);

        // Counter saturation at 3
        send_flag(0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            send_bits(0, 32'h3CA5, 16);
            send_flag(0, 1'b0);
            exp_ok = (exp_ok < 3) ? exp_ok + 1 : 3;
            chk($sformatf("t5_sat%0d", k), rd_ok, exp_ok[1:0]);
        end

        // Clear on the same edge as a good frame wins
        send_bits(0, 32'h3CA5, 16);
        send_flag(0, 1'b1);
        chk("t5_clr_evt", ok_evt, 3'b001);
        chk("t5_clr_rd",  {rd_ok, rd_err, rd_ab}, 6'd0);

        // Channel 1 frame and readout select
        clr_acc();
        send_flag(1, 1'b0);
        send_bits(1, 32'h3CA5, 16);
        send_flag(1, 1'b0);
        chk("t6_ch1_ok", ok_evt, 3'b010);
        chk("t6_sync",   in_sync, 3'b011);
        sel = 2'd1; #1;
        chk("t6_sel1", rd_ok, 2'd1);
        sel = 2'd3; #1;
        chk("t6_sel3", {rd_ok, rd_err, rd_ab}, 6'd0);
        sel = 2'd0; #1;
        chk("t6_sel0", rd_ok, 2'd0);

        // 64-bit payload is exactly the maximum
        send_bits(1, 32'h55555555, 32);
        send_bits(1, 32'h55555555, 32);
        send_flag(1, 1'b0);
        chk("t7_max_ok", ok_evt, 3'b010);

        // 72 content bits are tolerated, the 73rd overflows
        clr_acc();
        send_bits(1, 32'h55555555, 32);
        send_bits(1, 32'h55555555, 32);
        send_bits(1, 32'h55, 8);
        chk("t7_72_noerr", acc_err, 3'b000);
        send_bit(1, 1'b1);
        chk("t7_ovf_err",  err_evt, 3'b010);
        chk("t7_ovf_sync", in_sync, 3'b001);
        sel = 2'd1; #1;
        chk("t7_rd", {rd_ok, rd_err}, {2'd2, 2'd1});

        // Reset mid-frame on channel 0
        send_bits(0, 32'h3CA5, 12);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t8_rst_sync", in_sync, 3'b000);
        chk("t8_rst_evt",  {flag_evt, ok_evt, err_evt, ab_evt}, 12'd0);
        chk("t8_rst_rd",   {rd_ok, rd_err, rd_ab}, 6'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sel   = 2'd0;
        clr_acc();
        send_bits(0, 32'h3CA5, 16);
        chk("t8_noevt",   {acc_flag, acc_ok, acc_err, acc_ab}, 12'd0);
        chk("t8_nosync",  in_sync, 3'b000);
        send_flag(0, 1'b0);
        chk("t8_flag",    flag_evt, 3'b001);
        chk("t8_sync",    in_sync, 3'b001);
        chk("t8_noframe", acc_ok | acc_err, 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
